// File: rtl/semaforo_pkg.sv
// Shared constants for the traffic-light controller: system clock rate and
// the day/night detector state encoding.
package semaforo_pkg;

    localparam int unsigned CLK_FREQ_HZ = 50_000_000;

    typedef enum logic [1:0] {
        DIA      = 2'b00,
        A_NOCHE  = 2'b01,
        NOCHE_ST = 2'b10,
        A_DIA    = 2'b11
    } estado_t;

endpackage

// File: rtl/divisor_tick.sv
// Free-running divider: TICK is high for one CLK every DIV cycles, on the
// cycle the counter reaches DIV-1.
module divisor_tick #(
    parameter int unsigned DIV = 50_000
) (
    input  logic CLK,
    input  logic RST,
    output logic TICK
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    assign TICK = (cnt_q == CNT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (TICK) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/detector_noche.sv
// Day/night detector: synchronises the photoresistor, integrates it on a slow
// tick and commits NOCHE changes only after a hysteresis-qualified hold time.
module detector_noche
    import semaforo_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV   = 50_000,
    parameter int unsigned INT_W        = 8,
    parameter int unsigned HI_TH        = 192,
    parameter int unsigned LO_TH        = 64,
    parameter int unsigned HOLD_SAMPLES = 2000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FOTORES,
    output logic             NOCHE,
    output logic             CAMBIO,
    output logic [1:0]       ESTADO,
    output logic [INT_W-1:0] NIVEL
);

    localparam int unsigned HOLD_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_SAMPLES - 1);
    localparam logic [INT_W-1:0]  INT_MAX   = '1;
    localparam logic [INT_W-1:0]  HI_LVL    = INT_W'(HI_TH);
    localparam logic [INT_W-1:0]  LO_LVL    = INT_W'(LO_TH);

    logic              fot_meta;
    logic              fot_s;
    logic              tick;
    logic [INT_W-1:0]  nivel_q, nivel_d;
    estado_t           estado_q, estado_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              noche_q, noche_d;
    logic              cambio_q;

    divisor_tick #(
        .DIV (SAMPLE_DIV)
    ) u_divisor_tick (
        .CLK  (CLK),
        .RST  (RST),
        .TICK (tick)
    );

    // Saturating up/down integrator, stepped once per sample tick.
    always_comb begin
        nivel_d = nivel_q;
        if (tick) begin
            if (fot_s && (nivel_q != INT_MAX)) begin
                nivel_d = nivel_q + 1'b1;
            end else if (!fot_s && (nivel_q != '0)) begin
                nivel_d = nivel_q - 1'b1;
            end
        end
    end

    // FSM judges the level registered before this tick's integrator update.
    always_comb begin
        estado_d = estado_q;
        hold_d   = hold_q;
        noche_d  = noche_q;
        if (tick) begin
            unique case (estado_q)
                DIA: begin
                    if (nivel_q >= HI_LVL) begin
                        estado_d = A_NOCHE;
                        hold_d   = '0;
                    end
                end
                A_NOCHE: begin
                    if (nivel_q < HI_LVL) begin
                        estado_d = DIA;
                    end else if (hold_q == HOLD_LAST) begin
                        estado_d = NOCHE_ST;
                        noche_d  = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                NOCHE_ST: begin
                    if (nivel_q <= LO_LVL) begin
                        estado_d = A_DIA;
                        hold_d   = '0;
                    end
                end
                A_DIA: begin
                    if (nivel_q > LO_LVL) begin
                        estado_d = NOCHE_ST;
                    end else if (hold_q == HOLD_LAST) begin
                        estado_d = DIA;
                        noche_d  = 1'b0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: estado_d = DIA;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fot_meta <= 1'b0;
            fot_s    <= 1'b0;
            nivel_q  <= '0;
            estado_q <= DIA;
            hold_q   <= '0;
            noche_q  <= 1'b0;
            cambio_q <= 1'b0;
        end else begin
            fot_meta <= FOTORES;
            fot_s    <= fot_meta;
            nivel_q  <= nivel_d;
            estado_q <= estado_d;
            hold_q   <= hold_d;
            noche_q  <= noche_d;
            cambio_q <= noche_d ^ noche_q;
        end
    end

    assign NOCHE  = noche_q;
    assign CAMBIO = cambio_q;
    assign ESTADO = estado_q;
    assign NIVEL  = nivel_q;

endmodule

// File: tb/tb_detector_noche.sv
// Bench for detector_noche: fixed vector table, hand-written corner sequences and
// randomized runs, all checked every cycle against a behavioural model.
module tb_detector_noche;

    localparam int SAMPLE_DIV   = 4;
    localparam int INT_W        = 4;
    localparam int INT_MAX      = 15;
    localparam int HI_TH        = 12;
    localparam int LO_TH        = 4;
    localparam int HOLD_SAMPLES = 3;

    logic             CLK;
    logic             RST;
    logic             FOTORES;
    logic             NOCHE;
    logic             CAMBIO;
    logic [1:0]       ESTADO;
    logic [INT_W-1:0] NIVEL;

    detector_noche #(
        .SAMPLE_DIV   (SAMPLE_DIV),
        .INT_W        (INT_W),
        .HI_TH        (HI_TH),
        .LO_TH        (LO_TH),
        .HOLD_SAMPLES (HOLD_SAMPLES)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .FOTORES (FOTORES),
        .NOCHE   (NOCHE),
        .CAMBIO  (CAMBIO),
        .ESTADO  (ESTADO),
        .NIVEL   (NIVEL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [1:0] est, input logic noche,
                         input logic cambio, input int nivel);
        n_total++;
        if (ESTADO === est && NOCHE === noche && CAMBIO === cambio &&
            NIVEL === INT_W'(nivel)) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t: got estado=%0d noche=%0d cambio=%0d nivel=%0d, want estado=%0d noche=%0d cambio=%0d nivel=%0d",
                     name, $time, ESTADO, NOCHE, CAMBIO, NIVEL, est, noche, cambio, nivel);
        end
    endtask

    // Behavioural model: input seen two clocks late, level stepped every
    // SAMPLE_DIV clocks, and a streak of ticks leaning towards the other
    // mode; HOLD_SAMPLES+1 consecutive leaning ticks flip the mode.
    int m_nivel;
    int m_streak;
    int m_cycles;
    bit m_noche;
    bit m_cambio;
    bit m_fot_s;
    bit m_toward;
    bit m_hist[$];

    always @(posedge CLK) begin
        if (RST) begin
            m_nivel  = 0;
            m_streak = 0;
            m_cycles = 0;
            m_noche  = 1'b0;
            m_cambio = 1'b0;
            m_hist.delete();
            m_hist.push_back(1'b0);
            m_hist.push_back(1'b0);
        end else begin
            m_fot_s  = m_hist[0];
            m_cambio = 1'b0;
            if ((m_cycles + 1) % SAMPLE_DIV == 0) begin
                m_toward = m_noche ? (m_nivel <= LO_TH) : (m_nivel >= HI_TH);
                m_streak = m_toward ? m_streak + 1 : 0;
                if (m_streak == HOLD_SAMPLES + 1) begin
                    m_noche  = !m_noche;
                    m_cambio = 1'b1;
                    m_streak = 0;
                end
                if (m_fot_s) m_nivel = (m_nivel < INT_MAX) ? m_nivel + 1 : INT_MAX;
                else         m_nivel = (m_nivel > 0) ? m_nivel - 1 : 0;
            end
            void'(m_hist.pop_front());
            m_hist.push_back(FOTORES);
            m_cycles++;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) check("model", {m_noche, (m_streak > 0)}, m_noche, m_cambio, m_nivel);
    end

    typedef struct {
        logic       fot;
        int         clocks;
        logic [1:0] est;
        logic       noche;
        logic       cambio;
        int         nivel;
    } vec_t;

    vec_t vecs[13];

    task automatic run(input logic fot, input int n);
        FOTORES = fot;
        repeat (n) @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        // Dark from reset, then back to day; clocks are counted from release.
        vecs[0]  = '{1'b1, 4,  2'b00, 1'b0, 1'b0, 1};
        vecs[1]  = '{1'b1, 44, 2'b00, 1'b0, 1'b0, 12};
        vecs[2]  = '{1'b1, 4,  2'b01, 1'b0, 1'b0, 13};
        vecs[3]  = '{1'b1, 8,  2'b01, 1'b0, 1'b0, 15};
        vecs[4]  = '{1'b1, 3,  2'b01, 1'b0, 1'b0, 15};
        vecs[5]  = '{1'b1, 1,  2'b10, 1'b1, 1'b1, 15};
        vecs[6]  = '{1'b1, 1,  2'b10, 1'b1, 1'b0, 15};
        vecs[7]  = '{1'b0, 43, 2'b10, 1'b1, 1'b0, 4};
        vecs[8]  = '{1'b0, 4,  2'b11, 1'b1, 1'b0, 3};
        vecs[9]  = '{1'b0, 11, 2'b11, 1'b1, 1'b0, 1};
        vecs[10] = '{1'b0, 1,  2'b00, 1'b0, 1'b1, 0};
        vecs[11] = '{1'b0, 1,  2'b00, 1'b0, 1'b0, 0};
        vecs[12] = '{1'b0, 8,  2'b00, 1'b0, 1'b0, 0};

        RST     = 1'b1;
        FOTORES = 1'b0;
        repeat (2) @(negedge CLK);
        chk_en = 1'b1;
        check("reset_values", 2'b00, 1'b0, 1'b0, 0);
        RST = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run(vecs[i].fot, vecs[i].clocks);
            check($sformatf("vec%0d", i), vecs[i].est, vecs[i].noche, vecs[i].cambio,
                  vecs[i].nivel);
        end

        // Abort: A_NOCHE entered with the level already falling.
        FOTORES = 1'b1;
        do_reset();
        run(1'b1, 49);
        run(1'b0, 3);
        check("abort_enter", 2'b01, 1'b0, 1'b0, 11);
        run(1'b0, 1);
        run(1'b1, 3);
        check("abort_exit", 2'b00, 1'b0, 1'b0, 12);

        // Reset in A_DIA with HOLD=1.
        FOTORES = 1'b1;
        do_reset();
        run(1'b1, 65);
        run(1'b0, 51);
        check("a_dia_hold1", 2'b11, 1'b1, 1'b0, 2);
        RST = 1'b1;
        @(negedge CLK);
        check("mid_reset", 2'b00, 1'b0, 1'b0, 0);
        RST = 1'b0;

        // Glitches: one between ticks, one straddling a tick.
        FOTORES = 1'b1;
        do_reset();
        run(1'b1, 34);
        run(1'b0, 3);
        run(1'b1, 3);
        check("glitch_between", 2'b00, 1'b0, 1'b0, 10);
        run(1'b1, 1);
        run(1'b0, 3);
        check("glitch_on_tick", 2'b00, 1'b0, 1'b0, 9);
        run(1'b1, 4);
        check("glitch_recover", 2'b00, 1'b0, 1'b0, 10);

        // Hysteresis band from day and from night.
        FOTORES = 1'b1;
        do_reset();
        run(1'b1, 32);
        for (int i = 0; i < 50; i++) begin
            run(1'b0, 4);
            run(1'b1, 4);
        end
        check("hyst_day", 2'b00, 1'b0, 1'b0, 8);

        FOTORES = 1'b1;
        do_reset();
        run(1'b1, 65);
        run(1'b0, 31);
        for (int i = 0; i < 50; i++) begin
            run(1'b1, 4);
            run(1'b0, 4);
        end
        check("hyst_night", 2'b10, 1'b1, 1'b0, 7);

        // Randomized runs of dark/light with occasional resets.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                RST = 1'b1;
                @(negedge CLK);
                RST = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                run(1'($urandom_range(0, 1)), $urandom_range(1, 6));
            end else begin
                run(1'($urandom_range(0, 1)), $urandom_range(20, 160));
            end
        end
        run(FOTORES, 4);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
